jt49_mix: RTL and testbench
===========================

Name: jt49_mix

Overview:
- Channel mixer stage directly downstream of the noise generator and the three tone generators.
- Each cen sample, it gates each channel's tone bit with the shared noise bit under control of the mixer enable register.
- It then selects fixed amplitude or envelope level per channel and produces registered 5-bit per-channel levels.
- A short sequencer converts each level through a log-to-linear table and accumulates a 10-bit mono sum with a valid strobe for the DAC/filter stage.

Parameters:
- SUM_W, 10, width of the accumulated linear sum; must be at least 10 (3 × 255 = 765).
- LIN_W, 8, width of one linear table entry.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cen  in  1  PSG clock enable (direct enable); one sample is captured per cen pulse.
- tone  in  3  tone square outputs; bit0=A, bit1=B, bit2=C.
- noise  in  1  noise generator output bit.
- mix_dis  in  6  mixer register: [2:0] tone disable A/B/C, [5:3] noise disable A/B/C; 1 = disabled.
- amp_a  in  5  channel A amplitude register; bit4 = envelope mode, [3:0] = fixed level.
- amp_b  in  5  channel B amplitude register, same format.
- amp_c  in  5  channel C amplitude register, same format.
- env  in  5  envelope generator level, 0..31.
- level_a  out  5  channel A level, registered.
- level_b  out  5  channel B level, registered.
- level_c  out  5  channel C level, registered.
- sum  out  SUM_W  linear sum of lin[level_a] + lin[level_b] + lin[level_c].
- sum_valid  out  1  one-clk pulse when sum updates.

Behaviour:
- Reset (async, rst_n low): level_a/b/c=0, sum=0, sum_valid=0, accumulator=0, pending=0, FSM in IDLE.
- Gate per channel i: g = (tone[i] | mix_dis[i]) & (noise | mix_dis[i+3]). With both disables set, g is constant 1 and the channel outputs its amplitude (DC level).
- Raw level per channel: amp[4] ? env : {amp[3:0],1'b1}. Fixed level 0 therefore maps to 1, fixed 15 maps to 31.
- level_x = g ? raw : 0. Registered on the clk edge where cen=1; holds otherwise. Latency: 1 clk from the cen edge.
- The same cen edge sets pending=1.
- Sequencer runs every clk and is not cen-gated. States:
  - IDLE: if pending, clear pending, acc=0 → ACC_A.
  - ACC_A: acc += lin[level_a] → ACC_B.
  - ACC_B: acc += lin[level_b] → ACC_C.
  - ACC_C: acc += lin[level_c] → DONE.
  - DONE: sum <= acc, sum_valid=1 for this clk only → IDLE.
- Cycle timing: cen at edge N → levels visible after N; ACC_A at N+1; sum/sum_valid at N+5.
- Minimum cen spacing for no loss is 5 clk.
- A cen arriving while the FSM is busy overwrites the levels and sets pending. The current pass completes with mixed old/new levels, allowed as a transient. A second pass starts immediately from IDLE.
- Multiple cen pulses during one pass collapse into a single pending pass.
- cen and the DONE state on the same clk: both actions occur; sum_valid still pulses.
- Accumulator is SUM_W bits unsigned; with SUM_W≥10 it cannot overflow.
- Reset asserted mid-pass: abort immediately to the reset state; no sum_valid.

Decomposition:
- Shared package jt49_pkg holds:
  - LIN_TABLE: 32 × 8-bit, monotonic non-decreasing, lin[0]=0, lin[31]=255, approx. 1.5 dB/step.
  - Constants CH_A=0, CH_B=1, CH_C=2.
  - FSM state enum mix_st_t.
- One sub-module, jt49_mix_gate: combinational gate plus level select for one channel, instantiated three times.

Test Plan:
- Reset: rst_n low, drive arbitrary inputs and cen → levels=0, sum=0, sum_valid never 1.
- Fixed DC: mix_dis=6'b111111, amp_a=5'h0F, amp_b=amp_c=0, one cen → level_a=31, level_b=level_c=1; sum=255+2·lin[1] with sum_valid at cen+5 clk exactly.
- Gating: mix_dis=6'b111110, amp_a=5'h0F, tone[0] toggling 1/0 across cens → level_a alternates 31/0. Then mix_dis=6'b110111 with noise toggling → level_a follows noise.
- Envelope mode: amp_b=5'h10, env swept 0..31, gate open, tone=3'b111 → level_b==env on each sample; sum monotone.
- Back-to-back cen: cen on clk 0 and clk 2 → exactly two sum_valid pulses (clk 5 and clk 10); second sum reflects levels captured at clk 2.
- Reset at ACC_B state: rst_n pulsed low → no sum_valid, sum=0, FSM IDLE; next cen produces a correct sum at cen+5.

Source files
------------

// File: rtl/jt49_pkg.sv
// jt49_pkg: shared definitions for the jt49 mixer slice.
//   LIN_TABLE  - 32-entry log-to-linear amplitude table (about 1.5 dB/step,
//                lin[0] = 0, lin[31] = 255, monotonic non-decreasing)
//   CH_A/B/C   - channel bit positions in the tone and mixer vectors
//   mix_st_t   - sequencer state encoding
//   lin_lookup - table read helper
package jt49_pkg;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC_A = 3'd1,
    ST_ACC_B = 3'd2,
    ST_ACC_C = 3'd3,
    ST_DONE  = 3'd4
  } mix_st_t;

  // Level 0 is forced to silence; the rest follow 255 * 10^(-1.5*(31-i)/20).
  localparam logic [7:0] LIN_TABLE [32] = '{
    8'd0,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
    8'd5,   8'd6,   8'd7,   8'd8,   8'd10,  8'd11,  8'd14,  8'd16,
    8'd19,  8'd23,  8'd27,  8'd32,  8'd38,  8'd45,  8'd54,  8'd64,
    8'd76,  8'd90,  8'd108, 8'd128, 8'd152, 8'd181, 8'd215, 8'd255
  };

  function automatic logic [7:0] lin_lookup(input logic [4:0] lvl);
    return LIN_TABLE[lvl];
  endfunction

endpackage

// File: rtl/jt49_mix_gate.sv
// jt49_mix_gate: per-channel tone/noise gate and level select (combinational).
//   tone, noise         - current tone bit of this channel and shared noise bit
//   tone_dis, noise_dis - mixer disables for this channel (1 = disabled)
//   amp                 - amplitude register: bit4 = envelope mode, [3:0] = fixed
//   env                 - envelope level
//   level               - gated 5-bit level for this channel
module jt49_mix_gate (
  input  logic       tone,
  input  logic       noise,
  input  logic       tone_dis,
  input  logic       noise_dis,
  input  logic [4:0] amp,
  input  logic [4:0] env,
  output logic [4:0] level
);

  logic       gate_s;
  logic [4:0] raw_s;

  // A disabled source reads as 1, so both disables set gives a DC level.
  always_comb begin
    gate_s = (tone | tone_dis) & (noise | noise_dis);
    if (amp[4]) begin
      raw_s = env;
    end else begin
      // Fixed 4-bit levels sit on the odd steps of the 5-bit scale.
      raw_s = {amp[3:0], 1'b1};
    end
    if (gate_s) begin
      level = raw_s;
    end else begin
      level = 5'd0;
    end
  end

endmodule

// File: rtl/jt49_mix.sv
// jt49_mix: three-channel mixer with linear mono sum.
//   clk, rst_n          - clock, asynchronous active-low reset
//   cen                 - PSG clock enable; one sample captured per pulse
//   tone[2:0], noise    - generator outputs (bit0 = A)
//   mix_dis[5:0]        - [2:0] tone disable, [5:3] noise disable (1 = off)
//   amp_a/b/c, env      - amplitude registers and envelope level
//   level_a/b/c         - registered per-channel 5-bit levels
//   sum, sum_valid      - linear sum of the three levels, one-clk update strobe
module jt49_mix
  import jt49_pkg::*;
#(
  parameter int SUM_W = 10,
  parameter int LIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic [2:0]       tone,
  input  logic             noise,
  input  logic [5:0]       mix_dis,
  input  logic [4:0]       amp_a,
  input  logic [4:0]       amp_b,
  input  logic [4:0]       amp_c,
  input  logic [4:0]       env,
  output logic [4:0]       level_a,
  output logic [4:0]       level_b,
  output logic [4:0]       level_c,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid
);

  logic [4:0]       gate_a_s, gate_b_s, gate_c_s;
  logic [4:0]       level_a_d, level_b_d, level_c_d;
  logic [4:0]       level_a_q, level_b_q, level_c_q;
  logic             pending_d, pending_q;
  mix_st_t          st_d, st_q;
  logic [SUM_W-1:0] acc_d, acc_q;
  logic [SUM_W-1:0] sum_d, sum_q;
  logic             sum_valid_d, sum_valid_q;
  logic [4:0]       lvl_sel_s;
  logic [LIN_W-1:0] lin_s;
  logic [SUM_W-1:0] lin_ext_s;

  jt49_mix_gate u_gate_a (
    .tone(tone[CH_A]), .noise(noise),
    .tone_dis(mix_dis[CH_A]), .noise_dis(mix_dis[CH_A+3]),
    .amp(amp_a), .env(env), .level(gate_a_s)
  );

  jt49_mix_gate u_gate_b (
    .tone(tone[CH_B]), .noise(noise),
    .tone_dis(mix_dis[CH_B]), .noise_dis(mix_dis[CH_B+3]),
    .amp(amp_b), .env(env), .level(gate_b_s)
  );

  jt49_mix_gate u_gate_c (
    .tone(tone[CH_C]), .noise(noise),
    .tone_dis(mix_dis[CH_C]), .noise_dis(mix_dis[CH_C+3]),
    .amp(amp_c), .env(env), .level(gate_c_s)
  );

  // Level capture: sample gated levels on cen, hold otherwise.
  always_comb begin
    if (cen) begin
      level_a_d = gate_a_s;
      level_b_d = gate_b_s;
      level_c_d = gate_c_s;
    end else begin
      level_a_d = level_a_q;
      level_b_d = level_b_q;
      level_c_d = level_c_q;
    end
  end

  // Table operand for the current accumulation step.
  always_comb begin
    case (st_q)
      ST_ACC_A: lvl_sel_s = level_a_q;
      ST_ACC_B: lvl_sel_s = level_b_q;
      ST_ACC_C: lvl_sel_s = level_c_q;
      default:  lvl_sel_s = 5'd0;
    endcase
    lin_s     = LIN_W'(lin_lookup(lvl_sel_s));
    lin_ext_s = {{(SUM_W-LIN_W){1'b0}}, lin_s};
  end

  // Sequencer: one table read and add per clk, not gated by cen.
  always_comb begin
    st_d        = st_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    pending_d   = pending_q;
    case (st_q)
      ST_IDLE: begin
        if (pending_q) begin
          pending_d = 1'b0;
          acc_d     = {SUM_W{1'b0}};
          st_d      = ST_ACC_A;
        end else begin
          st_d      = ST_IDLE;
        end
      end
      ST_ACC_A: begin
        acc_d = acc_q + lin_ext_s;
        st_d  = ST_ACC_B;
      end
      ST_ACC_B: begin
        acc_d = acc_q + lin_ext_s;
        st_d  = ST_ACC_C;
      end
      ST_ACC_C: begin
        acc_d = acc_q + lin_ext_s;
        st_d  = ST_DONE;
      end
      ST_DONE: begin
        sum_d       = acc_q;
        sum_valid_d = 1'b1;
        st_d        = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
    // A new sample always requests a pass, even while one is consumed; any
    // number of cen pulses during a pass collapse into this single flag.
    if (cen) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_a_q   <= 5'd0;
      level_b_q   <= 5'd0;
      level_c_q   <= 5'd0;
      pending_q   <= 1'b0;
      st_q        <= ST_IDLE;
      acc_q       <= {SUM_W{1'b0}};
      sum_q       <= {SUM_W{1'b0}};
      sum_valid_q <= 1'b0;
    end else begin
      level_a_q   <= level_a_d;
      level_b_q   <= level_b_d;
      level_c_q   <= level_c_d;
      pending_q   <= pending_d;
      st_q        <= st_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign level_a   = level_a_q;
  assign level_b   = level_b_q;
  assign level_c   = level_c_q;
  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_jt49_mix.sv
module tb_jt49_mix;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic [2:0] tone;
  logic       noise;
  logic [5:0] mix_dis;
  logic [4:0] amp_a, amp_b, amp_c, env;
  logic [4:0] level_a, level_b, level_c;
  logic [9:0] sum;
  logic       sum_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference log-to-linear table (1.5 dB steps, 0 -> 0, 31 -> 255).
  localparam int LIN_REF [32] = '{
    0, 1, 2, 2, 2, 3, 3, 4, 5, 6, 7, 8, 10, 11, 14, 16,
    19, 23, 27, 32, 38, 45, 54, 64, 76, 90, 108, 128, 152, 181, 215, 255
  };

  typedef struct {
    logic [5:0] mix_dis;
    logic [2:0] tone;
    logic       noise;
    logic [4:0] amp_a, amp_b, amp_c, env;
    int         exp_a, exp_b, exp_c;
  } vec_t;

  vec_t vecs [8];

  jt49_mix #(.SUM_W(10), .LIN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .tone(tone), .noise(noise),
    .mix_dis(mix_dis), .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
    .env(env), .level_a(level_a), .level_b(level_b), .level_c(level_c),
    .sum(sum), .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    mix_dis = v.mix_dis; tone = v.tone; noise = v.noise;
    amp_a = v.amp_a; amp_b = v.amp_b; amp_c = v.amp_c; env = v.env;
  endtask

  // One isolated sample: cen, check levels, then wait (bounded) for sum_valid.
  task automatic run_vec(input vec_t v, input string tag, output int got_sum);
    int lat;
    int exp_sum;
    lat = -1;
    got_sum = -1;
    exp_sum = LIN_REF[v.exp_a] + LIN_REF[v.exp_b] + LIN_REF[v.exp_c];
    drive(v);
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    check({tag, "_level_a"}, int'(level_a), v.exp_a);
    check({tag, "_level_b"}, int'(level_b), v.exp_b);
    check({tag, "_level_c"}, int'(level_c), v.exp_c);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (lat < 0 && sum_valid) begin
        lat = k;
        got_sum = int'(sum);
      end
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_sum"}, got_sum, exp_sum);
  endtask

  initial begin
    int   s;
    int   prev;
    int   mask;
    int   sum2;
    logic seen;
    vec_t x;
    vec_t y;

    //           mix_dis     tone    noise amp_a  amp_b  amp_c  env    A   B   C
    vecs[0] = '{6'b111111, 3'b000, 1'b0, 5'h0F, 5'h00, 5'h00, 5'd0, 31,  1,  1};
    vecs[1] = '{6'b111110, 3'b001, 1'b0, 5'h0F, 5'h00, 5'h00, 5'd0, 31,  1,  1};
    vecs[2] = '{6'b111110, 3'b000, 1'b0, 5'h0F, 5'h00, 5'h00, 5'd0,  0,  1,  1};
    vecs[3] = '{6'b110111, 3'b000, 1'b1, 5'h0F, 5'h00, 5'h00, 5'd0, 31,  1,  1};
    vecs[4] = '{6'b110111, 3'b000, 1'b0, 5'h0F, 5'h00, 5'h00, 5'd0,  0,  1,  1};
    vecs[5] = '{6'b000000, 3'b111, 1'b1, 5'h10, 5'h05, 5'h1F, 5'd7,  7, 11,  7};
    vecs[6] = '{6'b000000, 3'b101, 1'b1, 5'h08, 5'h08, 5'h08, 5'd0, 17,  0, 17};
    vecs[7] = '{6'b000000, 3'b111, 1'b0, 5'h0F, 5'h0F, 5'h0F, 5'd9,  0,  0,  0};

    // Reset held with live inputs and cen pulses.
    rst_n = 1'b0;
    cen = 1'b0;
    drive(vecs[0]);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cen = ~cen;
      if (sum_valid) seen = 1'b1;
    end
    check("rst_level_a", int'(level_a), 0);
    check("rst_level_b", int'(level_b), 0);
    check("rst_level_c", int'(level_c), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_no_valid", int'(seen), 0);
    cen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), s);
    end

    // Envelope sweep on channel B; A and C fixed at level 1.
    prev = 0;
    x = '{6'b000000, 3'b111, 1'b1, 5'h00, 5'h10, 5'h00, 5'd0, 1, 0, 1};
    for (int e = 0; e < 32; e++) begin
      x.env   = 5'(e);
      x.exp_b = e;
      run_vec(x, $sformatf("env%0d", e), s);
      check($sformatf("env%0d_mono", e), int'(s >= prev), 1);
      prev = s;
    end

    // Back-to-back cen two clocks apart: two passes, at +5 and +10.
    x = vecs[0];
    y = '{6'b000000, 3'b111, 1'b1, 5'h08, 5'h10, 5'h03, 5'd20, 17, 20, 7};
    mask = 0;
    sum2 = -1;
    drive(x);
    cen = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (sum_valid) mask = mask | (1 << k);
      if (k == 10) sum2 = int'(sum);
      if (k == 0) cen = 1'b0;
      if (k == 1) begin
        drive(y);
        cen = 1'b1;
      end
      if (k == 2) cen = 1'b0;
    end
    check("b2b_valid_mask", mask, (1 << 5) | (1 << 10));
    check("b2b_second_sum", sum2, LIN_REF[17] + LIN_REF[20] + LIN_REF[7]);

    // Reset pulsed while the sequencer is in ACC_B.
    drive(vecs[0]);
    cen = 1'b1;
    @(negedge clk);           // after cen edge N
    cen = 1'b0;
    @(negedge clk);           // after N+1: ACC_A
    @(negedge clk);           // after N+2: ACC_B
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_sum", int'(sum), 0);
    check("midrst_level_a", int'(level_a), 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (sum_valid) seen = 1'b1;
    end
    check("midrst_no_valid", int'(seen), 0);
    run_vec(vecs[5], "after_rst", s);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
